// File: rtl/dkong_scandoubler.sv
// Line-doubling scan converter: captures one input line into a ping-pong bank
// and replays the previous line twice at the faster output pixel rate.
module dkong_scandoubler #(
  parameter int ACTIVE_W   = 256,
  parameter int OUT_DIV    = 5,
  parameter int OUT_HTOTAL = 384,
  parameter int HS_START   = 272,
  parameter int HS_END     = 304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_line_start,
  input  logic       in_pix_ce,
  input  logic       in_valid,
  input  logic [7:0] in_rgb,
  input  logic       in_vsync,
  output logic [7:0] out_rgb,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       ovf
);

  localparam int AW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int LW = $clog2(ACTIVE_W + 1);
  localparam int HW = (OUT_HTOTAL > 1) ? $clog2(OUT_HTOTAL) : 1;
  localparam int DW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LINE0 = 2'd1;
  localparam logic [1:0] LINE1 = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [7:0]    bank [2][ACTIVE_W];
  logic          wr_bank;
  logic [LW-1:0] wr_addr;
  logic [LW-1:0] line_len [2];
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] out_h;
  logic [1:0]    state;

  logic          pix_we;
  logic          out_ce;
  logic          slot_on;
  logic          slot_active;
  logic          slot_hs;
  logic          wr_room;

  logic          s1_load;
  logic          s1_active;
  logic          s1_pad;
  logic          s1_hs;
  logic [7:0]    s1_rgb;

  assign pix_we  = in_pix_ce & in_valid;
  assign wr_room = 32'(wr_addr) < ACTIVE_W;
  // A line start restarts the divider, so it suppresses any out_ce in the same cycle.
  assign out_ce  = (div_cnt == DW'(OUT_DIV - 1)) && !in_line_start;

  always_comb begin
    slot_on     = (state == LINE0) || (state == LINE1);
    slot_active = slot_on && (32'(out_h) < ACTIVE_W);
    slot_hs     = slot_on && (32'(out_h) >= HS_START) && (32'(out_h) < HS_END);
  end

  // Line storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && pix_we) begin
      if (in_line_start)
        bank[~wr_bank][0] <= in_rgb;
      else if (wr_room)
        bank[wr_bank][wr_addr[AW-1:0]] <= in_rgb;
    end
    if (out_ce && slot_active)
      s1_rgb <= bank[~wr_bank][out_h[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      line_len[0] <= '0;
      line_len[1] <= '0;
      div_cnt     <= '0;
      out_h       <= '0;
      out_vsync   <= 1'b0;
      ovf         <= 1'b0;
      s1_load     <= 1'b0;
      s1_active   <= 1'b0;
      s1_pad      <= 1'b0;
      s1_hs       <= 1'b0;
      out_rgb     <= '0;
      out_de      <= 1'b0;
      out_hsync   <= 1'b0;
    end else begin
      ovf <= pix_we && !in_line_start && !wr_room;

      if (in_line_start) begin
        line_len[wr_bank] <= wr_addr;
        wr_bank           <= ~wr_bank;
        wr_addr           <= pix_we ? LW'(1) : '0;
        out_vsync         <= in_vsync;
        div_cnt           <= '0;
        out_h             <= '0;
        state             <= LINE0;
      end else begin
        if (pix_we && wr_room)
          wr_addr <= wr_addr + LW'(1);
        div_cnt <= (div_cnt == DW'(OUT_DIV - 1)) ? '0 : div_cnt + DW'(1);
        if (out_ce && slot_on) begin
          if (out_h == HW'(OUT_HTOTAL - 1)) begin
            out_h <= '0;
            state <= (state == LINE0) ? LINE1 : HOLD;
          end else begin
            out_h <= out_h + HW'(1);
          end
        end
      end

      // Two-stage slot pipeline: RAM read/qualify, then output register.
      s1_load <= out_ce;
      if (out_ce) begin
        s1_active <= slot_active;
        s1_pad    <= 32'(out_h) >= 32'(line_len[~wr_bank]);
        s1_hs     <= slot_hs;
      end

      if (s1_load) begin
        out_rgb   <= (s1_active && !s1_pad) ? s1_rgb : '0;
        out_de    <= s1_active;
        out_hsync <= s1_hs;
      end
    end
  end

endmodule
